// File: rtl/prog_ctr_pkg.sv
// Shared types and default sizes for the program sequencer.
package prog_ctr_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} seq_state_t;

    localparam int PC_W   = 10;
    localparam int OFF_W  = 8;
    localparam int N_PROG = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the RUN state: stall > jump > branch > increment.
module pc_next_calc
    import prog_ctr_pkg::*;
#(
    parameter int L    = PC_W,
    parameter int OFFW = OFF_W
) (
    input  logic [L-1:0]    i_pc,
    input  logic            i_stall,
    input  logic            i_jump_en,
    input  logic [L-1:0]    i_jump_target,
    input  logic            i_branch_en,
    input  logic [OFFW-1:0] i_branch_off,
    output logic [L-1:0]    o_next_pc,
    output logic            o_ovf
);

    // Two guard bits: any set guard bit means the branch left 0..2**L-1.
    logic [L+1:0] w_pc_ext;
    logic [L+1:0] w_off_ext;
    logic [L+1:0] w_sum;

    assign w_pc_ext  = {2'b00, i_pc};
    assign w_off_ext = {{(L+2-OFFW){i_branch_off[OFFW-1]}}, i_branch_off};
    assign w_sum     = w_pc_ext + w_off_ext;

    always_comb begin
        o_next_pc = i_pc + L'(1);
        o_ovf     = 1'b0;
        if (i_stall) begin
            o_next_pc = i_pc;
        end else if (i_jump_en) begin
            o_next_pc = i_jump_target;
        end else if (i_branch_en) begin
            o_next_pc = w_sum[L-1:0];
            o_ovf     = |w_sum[L+1:L];
        end
    end

endmodule

// File: rtl/prog_ctr_seq.sv
// Multi-program sequencer: arms on Start, runs with jump/branch/stall, pulses Done on Halt.
module prog_ctr_seq
    import prog_ctr_pkg::*;
#(
    parameter int L     = PC_W,
    parameter int OFFW  = OFF_W,
    parameter int NPROG = N_PROG,
    parameter logic [NPROG-1:0][L-1:0] PROG_BASE = {
        L'(3 * (2 ** (L-2))), L'(2 * (2 ** (L-2))), L'(2 ** (L-2)), L'(0)},
    localparam int SELW = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [SELW-1:0] ProgSel,
    input  logic            Stall,
    input  logic            Halt,
    input  logic            JumpEn,
    input  logic [L-1:0]    JumpTarget,
    input  logic            BranchEn,
    input  logic [OFFW-1:0] BranchOff,
    output logic [L-1:0]    ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic [SELW-1:0] ProgId,
    output logic            Fault
);

    seq_state_t      r_state;
    logic [L-1:0]    r_pc;
    logic [SELW-1:0] r_id;
    logic            r_fault;

    seq_state_t      w_state_nxt;
    logic [L-1:0]    w_pc_nxt;
    logic [SELW-1:0] w_id_nxt;
    logic            w_fault_nxt;
    logic [SELW-1:0] w_sel;
    logic [L-1:0]    w_base;
    logic [L-1:0]    w_calc_pc;
    logic            w_calc_ovf;

    // Out-of-range selections fall back to program 0.
    assign w_sel  = (32'(ProgSel) < NPROG) ? ProgSel : '0;
    assign w_base = PROG_BASE[w_sel];

    pc_next_calc #(.L(L), .OFFW(OFFW)) u_calc (
        .i_pc          (r_pc),
        .i_stall       (Stall),
        .i_jump_en     (JumpEn),
        .i_jump_target (JumpTarget),
        .i_branch_en   (BranchEn),
        .i_branch_off  (BranchOff),
        .o_next_pc     (w_calc_pc),
        .o_ovf         (w_calc_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_id_nxt    = r_id;
        w_fault_nxt = r_fault;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = ARMED;
                    w_pc_nxt    = w_base;
                    w_id_nxt    = w_sel;
                    w_fault_nxt = 1'b0;
                end
            end
            ARMED: begin
                if (!Start) w_state_nxt = RUN;
            end
            RUN: begin
                if (Start) begin
                    w_state_nxt = ARMED;
                    w_pc_nxt    = w_base;
                    w_id_nxt    = w_sel;
                    w_fault_nxt = 1'b0;
                end else if (Halt) begin
                    w_state_nxt = DONE;
                end else begin
                    w_pc_nxt = w_calc_pc;
                    if (w_calc_ovf) w_fault_nxt = 1'b1;
                end
            end
            DONE: begin
                // Start here is deliberately ignored; IDLE sees it next cycle.
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_id    <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_id    <= w_id_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign ProgCtr = r_pc;
    assign ProgId  = r_id;
    assign Fault   = r_fault;
    assign Running = (r_state == RUN);
    assign Done    = (r_state == DONE);

endmodule
